// File: rtl/line_buffer.sv
// line_buffer: streaming 5-row line buffer feeding window_buffer.
// Accepts raster-order pixels, keeps the previous KERNEL_SIZE-1 rows in a
// rotating set of row slots and emits one vertical column per pixel once
// enough rows are buffered.
// Optional feature macro: LINE_BUFFER_STALL_CNT_EN adds a saturating
// output-stall cycle counter (stall_cnt), cleared on frame_done.
module line_buffer #(
    parameter int WIDTH       = 28,
    parameter int HEIGHT      = 28,
    parameter int KERNEL_SIZE = 5,
    parameter int DATA_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             pix_in,
    input  logic                          valid_pix_line,
    output logic                          ready_line,
    output logic [KERNEL_SIZE*DATA_W-1:0] col_data_out,
    output logic                          valid_line_win,
    input  logic                          ready_win,
    output logic                          frame_done
`ifdef LINE_BUFFER_STALL_CNT_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);

    localparam int ROWS = KERNEL_SIZE - 1;
    localparam int XW   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int RPW  = (ROWS   > 1) ? $clog2(ROWS)   : 1;

    localparam logic [XW-1:0]  X_LAST      = XW'(WIDTH - 1);
    localparam logic [YW-1:0]  Y_LAST      = YW'(HEIGHT - 1);
    localparam logic [YW-1:0]  Y_FILL_LAST = YW'(ROWS - 1);
    localparam logic [RPW-1:0] RP_LAST     = RPW'(ROWS - 1);

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] row_mem [ROWS][WIDTH];

    logic [XW-1:0]  x, x_next;
    logic [YW-1:0]  y, y_next;
    logic [RPW-1:0] rp, rp_next;

    logic hs_pix;
    logic hs_col;
    logic row_end;
    logic frame_end;
    logic col_load;
    logic frame_done_next;

    logic [RPW-1:0]                 wr_slot;
    logic [RPW-1:0]                 rd_slot [ROWS];
    logic [KERNEL_SIZE*DATA_W-1:0]  col_next;

    assign hs_pix     = valid_pix_line & ready_line;
    assign hs_col     = valid_line_win & ready_win;
    assign ready_line = (state == FILL) | ~valid_line_win | ready_win;
    assign row_end    = (x == X_LAST);
    assign frame_end  = row_end & (y == Y_LAST);

    // During FILL row y lands in slot y; while streaming the oldest slot is recycled.
    assign wr_slot = (state == FILL) ? y[RPW-1:0] : rp;

    // Next-state, raster counters and row-pointer rotation.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_next      = state;
        x_next          = x;
        y_next          = y;
        rp_next         = rp;
        col_load        = 1'b0;
        frame_done_next = 1'b0;
        if (hs_pix) begin
            if (row_end) begin
                x_next = '0;
                y_next = frame_end ? '0 : y + 1'b1;
            end else begin
                x_next = x + 1'b1;
            end
            case (state)
                FILL: begin
                    if (row_end && (y == Y_FILL_LAST)) begin
                        state_next = STREAM;
                        rp_next    = '0;
                    end
                end
                STREAM: begin
                    col_load = 1'b1;
                    if (frame_end) begin
                        state_next      = FILL;
                        rp_next         = '0;
                        frame_done_next = 1'b1;
                    end else if (row_end) begin
                        rp_next = (rp == RP_LAST) ? '0 : rp + 1'b1;
                    end
                end
                default: state_next = FILL;
            endcase
        end
    end

    // Physical slot of each logical row (0 = oldest), rotating with rp mod ROWS.
    always_comb begin
        logic [RPW:0] sum;
        sum = '0;
        for (int k = 0; k < ROWS; k++) begin
            sum = {1'b0, rp} + (RPW+1)'(k);
            if (sum >= (RPW+1)'(ROWS)) begin
                sum = sum - (RPW+1)'(ROWS);
            end
            rd_slot[k] = sum[RPW-1:0];
        end
    end

    // Assemble the column: stored rows oldest-first in the low bytes, live pixel on top.
    always_comb begin
        col_next = '0;
        for (int k = 0; k < ROWS; k++) begin
            col_next[k*DATA_W +: DATA_W] = row_mem[rd_slot[k]][x];
        end
        col_next[ROWS*DATA_W +: DATA_W] = pix_in;
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= FILL;
            x     <= '0;
            y     <= '0;
            rp    <= '0;
        end else begin
            state <= state_next;
            x     <= x_next;
            y     <= y_next;
            rp    <= rp_next;
        end
    end

    // Row storage write; the column read above sees the pre-write contents.
    always_ff @(posedge clk) begin
        // NOTE: row memory has no reset; FILL overwrites every slot before any read.
        if (hs_pix) begin
            row_mem[wr_slot][x] <= pix_in;
        end
    end

    // Single-entry output register; a new column loading beats a same-edge drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_line_win <= 1'b0;
            col_data_out   <= '0;
        end else if (col_load) begin
            valid_line_win <= 1'b1;
            col_data_out   <= col_next;
        end else if (hs_col) begin
            valid_line_win <= 1'b0;
        end
    end

    // End-of-frame pulse, one cycle after the final accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_done_next;
        end
    end

`ifdef LINE_BUFFER_STALL_CNT_EN
    // Saturating count of cycles where a column waits on the window buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (frame_done) begin
            stall_cnt <= '0;
        end else if (valid_line_win && !ready_win && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_line_buffer.sv
// tb_line_buffer: scoreboard bench for line_buffer.
// Stimulus pushes the expected column for every streamed pixel; a negedge
// monitor pops and compares on each column handshake.
`timescale 1ns/1ps
module tb_line_buffer;

    localparam int WIDTH       = 28;
    localparam int HEIGHT      = 28;
    localparam int KERNEL_SIZE = 5;
    localparam int DATA_W      = 8;
    localparam int CW          = KERNEL_SIZE * DATA_W;

    localparam logic [CW-1:0] FIRST_COL = 40'h70_54_38_1C_00;
    localparam logic [CW-1:0] LAST_COL  = 40'h0F_F3_D7_BB_9F;

    logic          clk;
    logic          rst;
    logic [7:0]    pix_in;
    logic          valid_pix_line;
    logic          ready_line;
    logic [CW-1:0] col_data_out;
    logic          valid_line_win;
    logic          ready_win;
    logic          frame_done;
`ifdef LINE_BUFFER_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    line_buffer #(
        .WIDTH       (WIDTH),
        .HEIGHT      (HEIGHT),
        .KERNEL_SIZE (KERNEL_SIZE),
        .DATA_W      (DATA_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pix_in         (pix_in),
        .valid_pix_line (valid_pix_line),
        .ready_line     (ready_line),
        .col_data_out   (col_data_out),
        .valid_line_win (valid_line_win),
        .ready_win      (ready_win),
        .frame_done     (frame_done)
`ifdef LINE_BUFFER_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int popped   = 0;
    int fd_count = 0;
    logic [CW-1:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [7:0] pixval(input int x, input int y);
        return 8'((y * WIDTH + x) % 256);
    endfunction

    function automatic logic [CW-1:0] exp_col(input int x, input int y);
        logic [CW-1:0] c;
        c = '0;
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            c[k*8 +: 8] = pixval(x, y - (KERNEL_SIZE - 1) + k);
        end
        return c;
    endfunction

    // Monitor: every column handshake must match the oldest expected column.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) fd_count++;
            if (valid_line_win && ready_win) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL col_unexpected: got %h expected none (t=%0t)", col_data_out, $time);
                end else begin
                    logic [CW-1:0] e;
                    e = exp_q.pop_front();
                    popped++;
                    if (col_data_out !== e) begin
                        $display("FAIL col: got %h expected %h (t=%0t)", col_data_out, e, $time);
                    end else begin
                        n_pass++;
                    end
                end
            end
        end
    end

    // Present one pixel and hold it until accepted; returns at posedge+1.
    task automatic send_pix(input int x, input int y);
        int waited;
        bit ok;
        pix_in         = pixval(x, y);
        valid_pix_line = 1'b1;
        waited = 0;
        ok     = 1'b0;
        while (!ok) begin
            @(negedge clk);
            if (ready_line) begin
                ok = 1'b1;
            end else begin
                waited++;
                if (waited >= 100) begin
                    check("accept_timeout", 64'(ready_line), 64'd1);
                    return;
                end
            end
        end
        @(posedge clk);
        #1;
        if (y >= KERNEL_SIZE - 1) exp_q.push_back(exp_col(x, y));
    endtask

    // Stream a frame; stop_at >= 0 halts before that raster index.
    task automatic send_frame(input bit bp, input int stop_at);
        for (int y = 0; y < HEIGHT; y++) begin
            for (int x = 0; x < WIDTH; x++) begin
                int idx;
                idx = y * WIDTH + x;
                if (idx == stop_at) return;
                send_pix(x, y);
                if (idx == 0) begin
                    check("frame_done_one_cycle", 64'(frame_done), 64'd0);
`ifdef LINE_BUFFER_STALL_CNT_EN
                    check("stall_cnt_cleared", 64'(stall_cnt), 64'd0);
`endif
                end
                if (idx == (KERNEL_SIZE - 1) * WIDTH - 1) begin
                    check("fill_no_valid", 64'(valid_line_win), 64'd0);
                end
                if (idx == (KERNEL_SIZE - 1) * WIDTH) begin
                    check("first_col_valid", 64'(valid_line_win), 64'd1);
                    check("first_col_data", 64'(col_data_out), 64'(FIRST_COL));
                end
                if (bp && y == 10 && x == 14) begin
                    logic [CW-1:0] held;
                    ready_win = 1'b0;
                    held      = col_data_out;
                    pix_in    = pixval(15, 10);
                    for (int i = 0; i < 10; i++) begin
                        @(negedge clk);
                        check("bp_col_stable", 64'(col_data_out), 64'(held));
                        check("bp_valid_held", 64'(valid_line_win), 64'd1);
                        check("bp_ready_line", 64'(ready_line), 64'd0);
                    end
                    @(posedge clk);
                    #1;
                    ready_win = 1'b1;
                end
                if (idx == WIDTH * HEIGHT - 1) begin
                    check("last_frame_done", 64'(frame_done), 64'd1);
                    check("last_col_valid", 64'(valid_line_win), 64'd1);
                    check("last_col_data", 64'(col_data_out), 64'(LAST_COL));
`ifdef LINE_BUFFER_STALL_CNT_EN
                    check("stall_cnt_frame", 64'(stall_cnt), bp ? 64'd10 : 64'd0);
`endif
                end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        pix_in         = '0;
        valid_pix_line = 1'b0;
        ready_win      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(valid_line_win), 64'd0);
        check("rst_col", 64'(col_data_out), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_ready_line", 64'(ready_line), 64'd1);
        rst = 1'b0;

        // Frame 1 with backpressure, frame 2 back-to-back.
        send_frame(1'b1, -1);
        send_frame(1'b0, -1);
        valid_pix_line = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Partial frame, reset at y=15 x=7, then a clean frame.
        send_frame(1'b0, 15 * WIDTH + 7);
        rst            = 1'b1;
        valid_pix_line = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midrst_valid", 64'(valid_line_win), 64'd0);
        check("midrst_col", 64'(col_data_out), 64'd0);
        check("midrst_frame_done", 64'(frame_done), 64'd0);
        rst = 1'b0;
        send_frame(1'b0, -1);
        valid_pix_line = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("total_columns", 64'(popped), 64'd2330);
        check("frame_done_count", 64'(fd_count), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
